// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, the decode valid/ready handshake, and the execute redirect.
// master = fetch_unit, slave = ROM/decode/execute side.
interface fetch_unit_if;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        br_wait;

    modport master (
        output rom_addr,
        input  rom_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        input  redirect_valid,
        input  redirect_pc,
        output br_wait
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        output redirect_valid,
        output redirect_pc,
        input  br_wait
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational ROM access, small instr/PC FIFO to decode.
// Unconditional B resolves in-stage; BR halts fetch until execute redirects.
//
// state   | meaning
// --------+--------------------------------------------------
// RUN     | fetching, one push per cycle when FIFO has room
// WAIT_BR | BR pushed, no fetch until redirect_valid
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {
        RUN,
        WAIT_BR
    } state_t;

    state_t        state;
    logic [15:0]   pc;
    logic [31:0]   mem_instr [DEPTH];
    logic [15:0]   mem_pc    [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic        pop;
    logic        push;
    logic        is_b;
    logic        is_br;
    logic [15:0] next_pc;

    assign is_b  = (bus.rom_data[31:26] == 6'b000101);
    assign is_br = (bus.rom_data[31:10] == 22'b1101011000011111000000);

    // sext(imm26) truncated to 16 bits is just the low 16 bits of the word
    assign next_pc = is_b ? (pc + bus.rom_data[15:0]) : (pc + 16'd1);

    assign pop  = (count != '0) & bus.instr_ready;
    assign push = !bus.redirect_valid & (state == RUN) & ((count < FULL) | pop);

    assign bus.rom_addr    = pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = mem_instr[rd_ptr];
    assign bus.instr_pc    = mem_pc[rd_ptr];
    assign bus.br_wait     = (state == WAIT_BR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            // flush wins over any same-cycle pop or push
            state  <= RUN;
            pc     <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= bus.rom_data;
                mem_pc[wr_ptr]    <= pc;
                wr_ptr            <= wr_ptr + 1'b1;
                pc                <= next_pc;
                if (is_br) begin
                    state <= WAIT_BR;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, B resolution, backpressure, BR wait,
// redirect flush and asynchronous reset, against hand-computed expectations.
module tb_fetch_unit;
    localparam logic [31:0] ADDI   = 32'h91000421;
    localparam logic [31:0] B_M6   = 32'h17FFFFFA;
    localparam logic [31:0] B_P2   = 32'h14000002;
    localparam logic [31:0] BR_XZR = 32'hD61F03E0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [31:0] rom [65536];

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(16'h0000),
        .DEPTH   (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = ADDI;
        rom[16'h000A] = B_M6;
        rom[16'hFFFF] = B_P2;
        rom[16'h0005] = BR_XZR;

        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;

        #2;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst_brwait", 32'(bus.br_wait), 32'd0);
        chk("rst_romaddr", 32'(bus.rom_addr), 32'd0);

        #10 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("seq_valid", 32'(bus.instr_valid), 32'd1);
            chk("seq_pc", 32'(bus.instr_pc), 32'(k));
            chk("seq_romaddr", 32'(bus.rom_addr), 32'(k + 1));
        end

        // B -6 at 0x000A
        redirect_to(16'h0008);
        chk("rd8_bubble", 32'(bus.instr_valid), 32'd0);
        chk("rd8_romaddr", 32'(bus.rom_addr), 32'h8);
        tick();
        chk("rd8_pc8", 32'(bus.instr_pc), 32'h8);
        tick();
        chk("rd8_pc9", 32'(bus.instr_pc), 32'h9);
        tick();
        chk("b_pc", 32'(bus.instr_pc), 32'hA);
        chk("b_word", bus.instr, B_M6);
        chk("b_romaddr", 32'(bus.rom_addr), 32'h4);
        tick();
        chk("b_target_valid", 32'(bus.instr_valid), 32'd1);
        chk("b_target_pc", 32'(bus.instr_pc), 32'h4);

        // B +2 at 0xFFFF wraps
        redirect_to(16'hFFFF);
        chk("wrap_bubble", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("wrap_bpc", 32'(bus.instr_pc), 32'hFFFF);
        chk("wrap_romaddr", 32'(bus.rom_addr), 32'h1);
        tick();
        chk("wrap_target", 32'(bus.instr_pc), 32'h1);

        // backpressure: five edges with instr_ready low starting at PC 0
        bus.instr_ready = 1'b0;
        redirect_to(16'h0000);
        chk("bp_bubble", 32'(bus.instr_valid), 32'd0);
        chk("bp_start_addr", 32'(bus.rom_addr), 32'h0);
        for (int k = 0; k < 4; k++) tick();
        chk("bp_romaddr", 32'(bus.rom_addr), 32'h2);
        chk("bp_head_valid", 32'(bus.instr_valid), 32'd1);
        chk("bp_head_pc", 32'(bus.instr_pc), 32'h0);
        chk("bp_head_word", bus.instr, ADDI);
        bus.instr_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("bp_drain_valid", 32'(bus.instr_valid), 32'd1);
            chk("bp_drain_pc", 32'(bus.instr_pc), 32'(k));
        end

        // BR at PC 5 halts fetch until redirect
        redirect_to(16'h0003);
        tick();
        chk("br_pc3", 32'(bus.instr_pc), 32'h3);
        tick();
        chk("br_pc4", 32'(bus.instr_pc), 32'h4);
        chk("br_not_yet", 32'(bus.br_wait), 32'd0);
        tick();
        chk("br_pc5", 32'(bus.instr_pc), 32'h5);
        chk("br_word", bus.instr, BR_XZR);
        chk("br_wait_set", 32'(bus.br_wait), 32'd1);
        chk("br_romaddr", 32'(bus.rom_addr), 32'h6);
        tick();
        chk("br_empty", 32'(bus.instr_valid), 32'd0);
        chk("br_wait_hold", 32'(bus.br_wait), 32'd1);
        tick();
        chk("br_frozen", 32'(bus.rom_addr), 32'h6);
        chk("br_wait_hold2", 32'(bus.br_wait), 32'd1);
        redirect_to(16'h0020);
        chk("br_wait_clr", 32'(bus.br_wait), 32'd0);
        chk("br_bubble", 32'(bus.instr_valid), 32'd0);
        chk("br_redir_addr", 32'(bus.rom_addr), 32'h20);
        tick();
        chk("br_target_valid", 32'(bus.instr_valid), 32'd1);
        chk("br_target_pc", 32'(bus.instr_pc), 32'h20);

        // redirect while full with a simultaneous pop
        bus.instr_ready = 1'b0;
        tick();
        tick();
        chk("full_valid", 32'(bus.instr_valid), 32'd1);
        chk("full_head", 32'(bus.instr_pc), 32'h20);
        chk("full_romaddr", 32'(bus.rom_addr), 32'h22);
        bus.instr_ready = 1'b1;
        redirect_to(16'h0040);
        chk("flush_bubble", 32'(bus.instr_valid), 32'd0);
        chk("flush_romaddr", 32'(bus.rom_addr), 32'h40);
        tick();
        chk("flush_target", 32'(bus.instr_pc), 32'h40);
        tick();
        chk("flush_next", 32'(bus.instr_pc), 32'h41);

        // asynchronous reset between edges while in BR wait
        redirect_to(16'h0004);
        tick();
        tick();
        chk("ar_pre_brwait", 32'(bus.br_wait), 32'd1);
        chk("ar_pre_valid", 32'(bus.instr_valid), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(bus.instr_valid), 32'd0);
        chk("ar_brwait", 32'(bus.br_wait), 32'd0);
        chk("ar_romaddr", 32'(bus.rom_addr), 32'h0);
        chk("ar_pc", 32'(bus.instr_pc), 32'h0);
        #2 reset = 1'b0;
        tick();
        chk("ar_restart_valid", 32'(bus.instr_valid), 32'd1);
        chk("ar_restart_pc", 32'(bus.instr_pc), 32'h0);
        chk("ar_restart_addr", 32'(bus.rom_addr), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
